// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the 8-digit seven-segment scanner.
package seg7_pkg;

    localparam int DIGITS = 8;
    localparam int SEG_W  = 7;

    // Active-low segment pattern, bit 6 = a ... bit 0 = g
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module seg7_decode
    import seg7_pkg::SEG_W;
    import seg7_pkg::hex_to_seg;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    // Table lookup
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 8-digit seven-segment scanner with frame-synchronous (tear-free) updates.
module seg7_scan
    import seg7_pkg::SEG_W;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DIGITS   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [DIGITS-1:0]     AN,
    output logic [SEG_W-1:0]      A2G,
    output logic                  DP,
    output logic                  frame_done
);

    localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [PW-1:0]    PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   pend_data_q, pend_data_d, disp_data_q, disp_data_d;
    logic [DIGITS-1:0]     pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [SEG_W-1:0]      a2g_q, a2g_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;
    logic                  tick, boundary;
    logic [3:0]            act_nib;
    logic [SEG_W-1:0]      act_seg;

    assign act_nib = disp_data_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (act_nib),
        .seg    (act_seg)
    );

    // Prescaler, digit index and the double-buffered display registers
    always_comb begin
        tick         = (presc_q == PRESC_MAX);
        boundary     = tick && (idx_q == IDX_LAST);
        presc_d      = tick ? '0 : presc_q + PW'(1);
        idx_d        = tick ? idx_q + IDX_W'(1) : idx_q;
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        pend_flag_d  = pend_flag_q;
        disp_data_d  = disp_data_q;
        disp_blank_d = disp_blank_q;
        disp_dp_d    = disp_dp_q;
        // A write landing on the boundary skips the pending stage entirely
        if (boundary && wr_en) begin
            disp_data_d  = wr_data;
            disp_blank_d = blank_mask;
            disp_dp_d    = dp_mask;
            pend_flag_d  = 1'b0;
        end else if (wr_en) begin
            pend_data_d  = wr_data;
            pend_blank_d = blank_mask;
            pend_dp_d    = dp_mask;
            pend_flag_d  = 1'b1;
        end else if (boundary && pend_flag_q) begin
            disp_data_d  = pend_data_q;
            disp_blank_d = pend_blank_q;
            disp_dp_d    = pend_dp_q;
            pend_flag_d  = 1'b0;
        end else begin
            pend_flag_d  = pend_flag_q;
        end
    end

    // Next registered drive for the active digit
    always_comb begin
        an_d         = {DIGITS{1'b1}};
        a2g_d        = {SEG_W{1'b1}};
        dp_d         = 1'b1;
        frame_done_d = boundary;
        if (disp_blank_q[idx_q]) begin
            an_d  = {DIGITS{1'b1}};
            a2g_d = {SEG_W{1'b1}};
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(DIGITS'(1) << idx_q);
            a2g_d = act_seg;
            dp_d  = ~disp_dp_q[idx_q];
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_blank_q <= {DIGITS{1'b1}};
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
            disp_data_q  <= '0;
            disp_blank_q <= {DIGITS{1'b1}};
            disp_dp_q    <= '0;
            an_q         <= {DIGITS{1'b1}};
            a2g_q        <= {SEG_W{1'b1}};
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            pend_flag_q  <= pend_flag_d;
            disp_data_q  <= disp_data_d;
            disp_blank_q <= disp_blank_d;
            disp_dp_q    <= disp_dp_d;
            an_q         <= an_d;
            a2g_q        <= a2g_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign AN         = an_q;
    assign A2G        = a2g_q;
    assign DP         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with SCAN_DIV=4: vector table plus frame-timing sequences.
module tb_seg7_scan;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [7:0]  blank_mask;
    logic [7:0]  dp_mask;
    logic [7:0]  AN;
    logic [6:0]  A2G;
    logic        DP;
    logic        frame_done;

    int total;
    int bad;

    seg7_scan #(.SCAN_DIV(4), .DIGITS(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .AN         (AN),
        .A2G        (A2G),
        .DP         (DP),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] data;
        logic [7:0]  blank;
        logic [7:0]  dpm;
        int          slot;
        logic [7:0]  an;
        logic [6:0]  a2g;
        logic        dp;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
        wr_en      = 1'b1;
        wr_data    = d;
        blank_mask = b;
        dp_mask    = p;
        step(1);
        wr_en      = 1'b0;
    endtask

    // Advance until frame_done is seen; returns the number of cycles taken
    task automatic wait_fd(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!frame_done && n < 100);
        if (!frame_done) chk("fd_timeout", 32'(n), 32'd32);
    endtask

    initial begin
        int n;
        int blank_errs;
        total = 0;
        bad   = 0;
        vecs[0]  = '{32'h12345678, 8'h00, 8'h00, 0, 8'hFE, 7'h00, 1'b1};
        vecs[1]  = '{32'h12345678, 8'h00, 8'h00, 7, 8'h7F, 7'h4F, 1'b1};
        vecs[2]  = '{32'h12345678, 8'h00, 8'h00, 3, 8'hF7, 7'h24, 1'b1};
        vecs[3]  = '{32'h89ABCDEF, 8'h00, 8'h04, 2, 8'hFB, 7'h42, 1'b0};
        vecs[4]  = '{32'h89ABCDEF, 8'h00, 8'h00, 0, 8'hFE, 7'h38, 1'b1};
        vecs[5]  = '{32'h76543210, 8'h00, 8'h00, 7, 8'h7F, 7'h0F, 1'b1};
        vecs[6]  = '{32'h76543210, 8'h00, 8'h00, 4, 8'hEF, 7'h4C, 1'b1};
        vecs[7]  = '{32'hEEEEEEEE, 8'h00, 8'hFF, 1, 8'hFD, 7'h30, 1'b0};
        vecs[8]  = '{32'h000000A0, 8'h00, 8'h00, 1, 8'hFD, 7'h08, 1'b1};
        vecs[9]  = '{32'h0000B000, 8'h00, 8'h00, 3, 8'hF7, 7'h60, 1'b1};
        vecs[10] = '{32'h00C00000, 8'h00, 8'h00, 5, 8'hDF, 7'h31, 1'b1};
        vecs[11] = '{32'h06000000, 8'h00, 8'h00, 6, 8'hBF, 7'h20, 1'b1};
        vecs[12] = '{32'h30000000, 8'h00, 8'h00, 7, 8'h7F, 7'h06, 1'b1};
        vecs[13] = '{32'h00000200, 8'h00, 8'h00, 2, 8'hFB, 7'h12, 1'b1};
        vecs[14] = '{32'h00000009, 8'h00, 8'h00, 0, 8'hFE, 7'h04, 1'b1};
        vecs[15] = '{32'h12345678, 8'hF0, 8'h01, 0, 8'hFE, 7'h00, 1'b0};
        vecs[16] = '{32'h12345678, 8'hF0, 8'h01, 5, 8'hFF, 7'h7F, 1'b1};
        vecs[17] = '{32'h12345678, 8'h02, 8'h02, 1, 8'hFF, 7'h7F, 1'b1};
        vecs[18] = '{32'h76543210, 8'h00, 8'h00, 0, 8'hFE, 7'h01, 1'b1};

        reset_n    = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 32'h0;
        blank_mask = 8'h00;
        dp_mask    = 8'h00;
        step(10);
        chk("rst_an", 32'(AN), 32'hFF);
        chk("rst_a2g", 32'(A2G), 32'h7F);
        chk("rst_dp", 32'(DP), 32'h1);
        chk("rst_fd", 32'(frame_done), 32'h0);

        // First frame: pending write made early, committed at the first boundary
        reset_n = 1'b1;
        step(2);
        chk("pre_commit_an", 32'(AN), 32'hFF);
        wr(32'h12345678, 8'h00, 8'h00);
        n = 3;
        while (!frame_done && n < 100) begin
            step(1);
            n++;
        end
        chk("first_fd_cycles", 32'(n), 32'd32);
        step(1);
        chk("first_fd_width", 32'(frame_done), 32'h0);
        chk("f1_slot0_an", 32'(AN), 32'hFE);
        chk("f1_slot0_a2g", 32'(A2G), 32'h00);
        step(28);
        chk("f1_slot7_an", 32'(AN), 32'h7F);
        chk("f1_slot7_a2g", 32'(A2G), 32'h4F);
        wait_fd(n);
        wait_fd(n);
        chk("fd_period", 32'(n), 32'd32);

        foreach (vecs[i]) begin
            wr(vecs[i].data, vecs[i].blank, vecs[i].dpm);
            wait_fd(n);
            step(1 + 4 * vecs[i].slot);
            chk($sformatf("vec%0d_an", i), 32'(AN), 32'(vecs[i].an));
            chk($sformatf("vec%0d_a2g", i), 32'(A2G), 32'(vecs[i].a2g));
            chk($sformatf("vec%0d_dp", i), 32'(DP), 32'(vecs[i].dp));
            wait_fd(n);
        end

        // Two mid-frame writes: current frame untouched, last write wins next frame
        wr(32'h11111111, 8'h00, 8'h00);
        wait_fd(n);
        wr(32'hAAAAAAAA, 8'h00, 8'h00);
        wr(32'h0000000F, 8'h00, 8'h00);
        step(11);
        chk("tear_slot3_an", 32'(AN), 32'hF7);
        chk("tear_slot3_a2g", 32'(A2G), 32'h4F);
        wait_fd(n);
        step(1);
        chk("lastwr_d0_a2g", 32'(A2G), 32'h38);
        step(4);
        chk("lastwr_d1_a2g", 32'(A2G), 32'h01);

        // Write in the exact boundary cycle shows in the very next frame
        wait_fd(n);
        step(31);
        wr(32'hCAFE0001, 8'h00, 8'h00);
        chk("bypass_fd", 32'(frame_done), 32'h1);
        step(1);
        chk("bypass_d0_an", 32'(AN), 32'hFE);
        chk("bypass_d0_a2g", 32'(A2G), 32'h4F);
        step(28);
        chk("bypass_d7_a2g", 32'(A2G), 32'h31);
        wait_fd(n);
        step(1);
        chk("bypass_hold_a2g", 32'(A2G), 32'h4F);

        // Upper digits blanked, DP only on digit 0, across a full frame
        wr(32'h12345678, 8'hF0, 8'h01);
        wait_fd(n);
        blank_errs = 0;
        for (int c = 0; c < 32; c++) begin
            step(1);
            if (AN[7:4] != 4'hF) blank_errs++;
            if ((DP == 1'b0) != (AN == 8'hFE)) blank_errs++;
        end
        chk("blank_dp_frame", 32'(blank_errs), 32'd0);

        // Reset at digit 3 of a displaying frame, with a write still pending
        wait_fd(n);
        step(13);
        chk("prerst_slot3_an", 32'(AN), 32'hF7);
        wr(32'h99999999, 8'h00, 8'h00);
        reset_n = 1'b0;
        #1;
        chk("midrst_an", 32'(AN), 32'hFF);
        chk("midrst_a2g", 32'(A2G), 32'h7F);
        chk("midrst_dp", 32'(DP), 32'h1);
        step(2);
        chk("midrst_fd", 32'(frame_done), 32'h0);
        reset_n = 1'b1;
        wait_fd(n);
        chk("postrst_fd_cycles", 32'(n), 32'd32);
        step(1);
        chk("postrst_an", 32'(AN), 32'hFF);
        chk("postrst_a2g", 32'(A2G), 32'h7F);
        chk("postrst_dp", 32'(DP), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
